sync_fifo_param: RTL

//  Parametrised single-clock FIFO, the next generation of the fixed 200x8 line-delay FIFO in the Sobel edge path.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/sdp_ram.sv | 38 +++
 rtl/sync_fifo_param.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and the pointer/level width helpers
// used by the line-buffer and window blocks.
package fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   // Address width for a DEPTH-entry array; never narrower than one bit.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Width able to hold every occupancy value 0..depth inclusive.
   function automatic int level_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module sdp_ram #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 200,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // NOTE: the array is deliberately left without reset so it maps onto block RAM;
   // only the read register is reset, because it drives a visible output.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (re_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// level/threshold flags and sticky overflow/underflow.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 200,
   parameter int FWFT      = FIFO_STD,
   parameter int AF_THRESH = 196,
   parameter int AE_THRESH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic [WIDTH-1:0]          din,
   input  logic                      wr_en,
   input  logic                      rd_en,
   output logic [WIDTH-1:0]          dout,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [level_w(DEPTH)-1:0] level,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int ADDR_W = addr_w(DEPTH);
   localparam int LVL_W  = level_w(DEPTH);

   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
   localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0]  LVL_AF   = LVL_W'(AF_THRESH);
   localparam logic [LVL_W-1:0]  LVL_AE   = LVL_W'(AE_THRESH);

   generate
      if (DEPTH < 2) begin : g_err_depth
         $error("sync_fifo_param: DEPTH must be at least 2");
      end
      if (AF_THRESH > DEPTH) begin : g_err_af
         $error("sync_fifo_param: AF_THRESH must not exceed DEPTH");
      end
      if (AE_THRESH >= DEPTH) begin : g_err_ae
         $error("sync_fifo_param: AE_THRESH must be below DEPTH");
      end
   endgenerate

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              write_acc, read_acc;
   logic              ram_we, ram_rd;
   logic              empty_w;

   // Explicit wrap so non-power-of-two depths never rely on modulo-2^n overflow.
   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_ONE;
   endfunction

   assign full         = (level_q == LVL_FULL);
   assign almost_full  = (level_q >= LVL_AF);
   assign almost_empty = (level_q <= LVL_AE);
   assign empty        = empty_w;
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign write_acc = wr_en && !full;
   assign read_acc  = rd_en && !empty_w;
   assign ram_we    = write_acc && !clr && rst_n;

   generate
      if (FWFT == FIFO_FWFT) begin : g_fwft
         logic out_valid_q, out_valid_d;
         logic ram_has_data;

         // The output register counts toward level, so RAM holds level minus out_valid words.
         always_comb begin
            ram_has_data = (level_q != LVL_W'(out_valid_q));
            ram_rd       = !clr && ram_has_data && (!out_valid_q || read_acc);
            out_valid_d  = out_valid_q;
            if (clr) begin
               out_valid_d = 1'b0;
            end else if (ram_rd) begin
               out_valid_d = 1'b1;
            end else if (read_acc) begin
               out_valid_d = 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               out_valid_q <= 1'b0;
            end else begin
               out_valid_q <= out_valid_d;
            end
         end

         assign empty_w = !out_valid_q;
      end else begin : g_std
         assign ram_rd  = read_acc && !clr;
         assign empty_w = (level_q == '0);
      end
   endgenerate

   // NOTE: every signal gets its hold value first so no path through this block infers a latch.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      overflow_d  = overflow_q || (wr_en && full);
      underflow_d = underflow_q || (rd_en && empty_w);
      if (write_acc) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (ram_rd) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({write_acc, read_acc})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
      if (clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   sdp_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (ram_we),
      .wr_addr_i(wr_ptr_q),
      .wr_data_i(din),
      .re_i     (ram_rd),
      .rd_addr_i(rd_ptr_q),
      .rd_data_o(dout)
   );

endmodule
